// File: rtl/rs_encode_pkg.sv
// Shared RS encoder constants plus the sizing helpers and state type used by
// the byte-to-line output converter.
package rs_encode_pkg;

  localparam int RS_N      = 255;
  localparam int RS_WORD_W = 8;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } out_state_e;

  function automatic int calc_num_lines(input int data_bytes);
    return (RS_N + data_bytes - 32'sd1) / data_bytes;
  endfunction

  // A codeword that fills its last line exactly reports a full line, not zero.
  function automatic int calc_last_line_bytes(input int data_bytes);
    int rem;
    rem = RS_N % data_bytes;
    if (rem == 32'sd0) begin
      return data_bytes;
    end else begin
      return rem;
    end
  endfunction

endpackage

// File: rtl/rs_encode_line_demux_out_ctrl.sv
// Control for the byte-to-line converter: accumulate/output FSM, byte and line
// counters, upstream/downstream handshakes and the codeword-done pulse.
module rs_encode_line_out_ctrl
  import rs_encode_pkg::*;
#(
  parameter int DATA_BYTES   = 32,
  parameter int DATA_BYTES_W = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    byte_val_i,
  input  logic                    line_rdy_i,
  output logic                    byte_rdy_o,
  output logic                    line_val_o,
  output logic                    line_last_o,
  output logic                    done_o,
  output logic                    byte_wr_o,
  output logic [DATA_BYTES_W-1:0] byte_idx_o,
  output logic                    line_clr_o
);

  localparam int NUM_OUT_LINES   = calc_num_lines(DATA_BYTES);
  localparam int LAST_LINE_BYTES = calc_last_line_bytes(DATA_BYTES);
  localparam int LINE_CNT_W      = $clog2(NUM_OUT_LINES + 1);

  localparam logic [DATA_BYTES_W-1:0] FULL_IDX  = DATA_BYTES_W'(DATA_BYTES - 1);
  localparam logic [DATA_BYTES_W-1:0] LAST_IDX  = DATA_BYTES_W'(LAST_LINE_BYTES - 1);
  localparam logic [LINE_CNT_W-1:0]   LAST_LINE = LINE_CNT_W'(NUM_OUT_LINES - 1);

  out_state_e              state_q;
  logic [DATA_BYTES_W-1:0] byte_cnt_q;
  logic [LINE_CNT_W-1:0]   line_cnt_q;
  logic                    byte_rdy_q;
  logic                    line_val_q;
  logic                    line_last_q;

  logic byte_acc_s;
  logic last_line_s;
  logic line_full_s;
  logic line_hs_s;

  assign byte_acc_s  = (state_q == ACCUM) && byte_rdy_q && byte_val_i;
  assign last_line_s = (line_cnt_q == LAST_LINE);
  assign line_full_s = (byte_cnt_q == FULL_IDX) || (last_line_s && (byte_cnt_q == LAST_IDX));
  assign line_hs_s   = line_val_q && line_rdy_i;

  // rdy is registered, so it comes up one cycle after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      byte_cnt_q  <= '0;
      line_cnt_q  <= '0;
      byte_rdy_q  <= 1'b0;
      line_val_q  <= 1'b0;
      line_last_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          byte_rdy_q  <= 1'b1;
          line_val_q  <= 1'b0;
          line_last_q <= 1'b0;
          if (byte_acc_s) begin
            if (line_full_s) begin
              state_q     <= OUTPUT;
              byte_rdy_q  <= 1'b0;
              line_val_q  <= 1'b1;
              line_last_q <= last_line_s;
            end else begin
              byte_cnt_q <= byte_cnt_q + DATA_BYTES_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (line_hs_s) begin
            state_q     <= ACCUM;
            byte_cnt_q  <= '0;
            byte_rdy_q  <= 1'b1;
            line_val_q  <= 1'b0;
            line_last_q <= 1'b0;
            if (line_last_q) begin
              line_cnt_q <= '0;
            end else begin
              line_cnt_q <= line_cnt_q + LINE_CNT_W'(1);
            end
          end
        end
        default: begin
          state_q     <= ACCUM;
          byte_cnt_q  <= '0;
          line_cnt_q  <= '0;
          byte_rdy_q  <= 1'b0;
          line_val_q  <= 1'b0;
          line_last_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_rdy_o  = byte_rdy_q;
  assign line_val_o  = line_val_q;
  assign line_last_o = line_last_q;
  assign done_o      = line_hs_s && line_last_q;
  assign byte_wr_o   = byte_acc_s;
  assign byte_idx_o  = byte_cnt_q;
  assign line_clr_o  = line_hs_s;

endmodule

// File: rtl/rs_encode_line_demux_out.sv
// Packs the RS encoder's byte-serial codeword into DATA_W-wide lines, first
// symbol in the MSBs, flagging the final line and signalling codeword done.
module rs_encode_line_demux_out
  import rs_encode_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 encoder_dst_byte_val,
  input  logic [RS_WORD_W-1:0] encoder_dst_byte,
  output logic                 dst_encoder_byte_rdy,
  output logic                 out_dst_line_val,
  output logic [DATA_W-1:0]    out_dst_line,
  output logic                 out_dst_line_last,
  input  logic                 dst_out_line_rdy,
  output logic                 out_ctrl_in_ctrl_done
);

  localparam int DATA_BYTES   = DATA_W / RS_WORD_W;
  localparam int DATA_BYTES_W = $clog2(DATA_BYTES);

  logic                    byte_wr_s;
  logic [DATA_BYTES_W-1:0] byte_idx_s;
  logic                    line_clr_s;
  logic [DATA_W-1:0]       line_q;
  logic [DATA_W-1:0]       line_d;

  rs_encode_line_out_ctrl #(
    .DATA_BYTES   (DATA_BYTES),
    .DATA_BYTES_W (DATA_BYTES_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .byte_val_i  (encoder_dst_byte_val),
    .line_rdy_i  (dst_out_line_rdy),
    .byte_rdy_o  (dst_encoder_byte_rdy),
    .line_val_o  (out_dst_line_val),
    .line_last_o (out_dst_line_last),
    .done_o      (out_ctrl_in_ctrl_done),
    .byte_wr_o   (byte_wr_s),
    .byte_idx_o  (byte_idx_s),
    .line_clr_o  (line_clr_s)
  );

  // Clearing on handshake leaves the unused tail of a short last line at zero.
  always_comb begin
    line_d = line_q;
    if (line_clr_s) begin
      line_d = '0;
    end else if (byte_wr_s) begin
      line_d[DATA_W - RS_WORD_W * (int'(byte_idx_s) + 1) +: RS_WORD_W] = encoder_dst_byte;
    end else begin
      line_d = line_q;
    end
  end

  // Line register, dropped entirely on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign out_dst_line = line_q;

endmodule

// File: tb/tb_rs_encode_line_demux_out.sv
// Randomized directed bench for rs_encode_line_demux_out at 64- and 256-bit line widths.
module tb_rs_encode_line_demux_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_val = 1'b0, a_lrdy = 1'b0;
  logic [7:0]  a_byte = 8'h00;
  logic        a_brdy, a_lval, a_last, a_done;
  logic [63:0] a_line;

  logic         b_val = 1'b0, b_lrdy = 1'b0;
  logic [7:0]   b_byte = 8'h00;
  logic         b_brdy, b_lval, b_last, b_done;
  logic [255:0] b_line;

  rs_encode_line_demux_out #(.DATA_W(64)) dut_a (
    .clk(clk), .rst(rst),
    .encoder_dst_byte_val(a_val), .encoder_dst_byte(a_byte),
    .dst_encoder_byte_rdy(a_brdy),
    .out_dst_line_val(a_lval), .out_dst_line(a_line), .out_dst_line_last(a_last),
    .dst_out_line_rdy(a_lrdy), .out_ctrl_in_ctrl_done(a_done)
  );

  rs_encode_line_demux_out #(.DATA_W(256)) dut_b (
    .clk(clk), .rst(rst),
    .encoder_dst_byte_val(b_val), .encoder_dst_byte(b_byte),
    .dst_encoder_byte_rdy(b_brdy),
    .out_dst_line_val(b_lval), .out_dst_line(b_line), .out_dst_line_last(b_last),
    .dst_out_line_rdy(b_lrdy), .out_ctrl_in_ctrl_done(b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_a   = 0;
  int stall_cnt_a = 0;
  logic [63:0] seen_a[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reset both DUTs with inputs active, checking quiet outputs throughout.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; a_val = 1'b1; a_lrdy = 1'b1; b_val = 1'b1; b_lrdy = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); #1;
      chk("rst_a_brdy", a_brdy, 1'b0);
      chk("rst_a_lval", a_lval, 1'b0);
      chk("rst_a_line", a_line, 64'h0);
      chk("rst_a_last", a_last, 1'b0);
      chk("rst_a_done", a_done, 1'b0);
      chk("rst_b_brdy", b_brdy, 1'b0);
      chk("rst_b_line", b_line, 256'h0);
      chk("rst_b_done", b_done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_a_brdy", a_brdy, 1'b1);
    chk("post_rst_a_lval", a_lval, 1'b0);
    chk("post_rst_a_line", a_line, 64'h0);
    chk("post_rst_b_brdy", b_brdy, 1'b1);
    a_val = 1'b0; a_lrdy = 1'b0; b_val = 1'b0; b_lrdy = 1'b0;
  endtask

  // Stream n_cw codewords into the 64-bit DUT and score every accepted line.
  task automatic run_a(input int n_cw, input int val_pct, input int rdy_pct,
                       input int stall_line, input int stall_len,
                       input int abort_at, input bit ramp);
    logic [7:0]  src[$];
    logic [63:0] exp_l[$];
    bit          exp_last[$];
    logic [63:0] ln, prev_line;
    logic        prev_last;
    bit          stalled, stall_now;
    int          sent, got, nl, idx;
    nl = (255 + 8 - 1) / 8;
    for (int c = 0; c < n_cw; c++)
      for (int i = 0; i < 255; i++)
        src.push_back(ramp ? 8'(i) : 8'($urandom_range(255)));
    for (int c = 0; c < n_cw; c++)
      for (int l = 0; l < nl; l++) begin
        ln = 64'h0;
        for (int k = 0; k < 8; k++) begin
          idx = l * 8 + k;
          ln = {ln[55:0], (idx < 255) ? src[c * 255 + idx] : 8'h00};
        end
        exp_l.push_back(ln);
        exp_last.push_back(l == nl - 1);
      end
    seen_a = {}; done_a = 0; stall_cnt_a = 0;
    sent = 0; got = 0; stalled = 1'b0; prev_line = 64'h0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (abort_at >= 0 && sent >= abort_at) break;
      if (abort_at < 0 && got >= exp_l.size()) break;
      @(negedge clk);
      a_val  = (sent < src.size()) && ($urandom_range(99) < val_pct);
      a_byte = (sent < src.size()) ? src[sent] : 8'h00;
      stall_now = (got == stall_line) && (stall_cnt_a < stall_len);
      a_lrdy = stall_now ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (stall_now && a_lval) stall_cnt_a++;
      #1;
      chk("a_rdy_excl", a_brdy, !a_lval);
      if (stalled) begin
        chk("a_hold_val", a_lval, 1'b1);
        chk("a_hold_line", a_line, prev_line);
        chk("a_hold_last", a_last, prev_last);
      end
      if (a_lval && a_lrdy) begin
        if (got < exp_l.size()) begin
          chk("a_line", a_line, exp_l[got]);
          chk("a_last", a_last, exp_last[got]);
          chk("a_done", a_done, exp_last[got]);
        end else begin
          chk("a_extra_line", got, exp_l.size());
        end
        seen_a.push_back(a_line);
        got++;
      end else begin
        chk("a_done_idle", a_done, 1'b0);
      end
      if (a_done) done_a++;
      stalled   = a_lval && !a_lrdy;
      prev_line = a_line;
      prev_last = a_last;
      if (a_val && a_brdy) sent++;
    end
    if (abort_at < 0) chk("a_lines_received", got, exp_l.size());
    @(negedge clk);
    a_val = 1'b0; a_lrdy = 1'b0;
  endtask

  // Ramp codeword into the 256-bit DUT with the downstream always ready.
  task automatic run_b();
    logic [255:0] exp_l[$];
    bit           exp_last[$];
    logic [255:0] ln;
    int           sent, got, nl, idx;
    logic [255:0] line7;
    line7 = 256'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEFF0F1F2F3F4F5F6F7F8F9FAFBFCFDFE00;
    nl = (255 + 32 - 1) / 32;
    for (int l = 0; l < nl; l++) begin
      ln = 256'h0;
      for (int k = 0; k < 32; k++) begin
        idx = l * 32 + k;
        ln = {ln[247:0], (idx < 255) ? 8'(idx) : 8'h00};
      end
      exp_l.push_back(ln);
      exp_last.push_back(l == nl - 1);
    end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (got >= nl) break;
      @(negedge clk);
      b_val  = (sent < 255);
      b_byte = 8'(sent);
      b_lrdy = 1'b1;
      #1;
      chk("b_rdy_excl", b_brdy, !b_lval);
      if (b_lval && b_lrdy) begin
        if (got < nl) begin
          chk("b_line", b_line, exp_l[got]);
          chk("b_last", b_last, exp_last[got]);
          chk("b_done", b_done, exp_last[got]);
          if (got == nl - 1) chk("b_line7_const", b_line, line7);
        end
        got++;
      end else begin
        chk("b_done_idle", b_done, 1'b0);
      end
      if (b_val && b_brdy) sent++;
    end
    chk("b_lines_received", got, nl);
    @(negedge clk);
    b_val = 1'b0; b_lrdy = 1'b0;
  endtask

  initial begin
    // Reset values and rdy after release
    do_reset(3);

    // 64-bit lines, ramp 0..254, no backpressure
    run_a(1, 100, 100, -1, 0, -1, 1'b1);
    chk("t1_nlines", seen_a.size(), 32);
    if (seen_a.size() >= 32) begin
      chk("t1_line0", seen_a[0], 64'h0001020304050607);
      chk("t1_line31", seen_a[31], 64'hF8F9FAFBFCFDFE00);
    end
    chk("t1_done_count", done_a, 1);

    // 256-bit lines, ramp
    run_b();

    // Downstream stall of 5 cycles on line 3
    run_a(1, 100, 100, 3, 5, -1, 1'b1);
    chk("t3_stall_cycles", stall_cnt_a, 5);
    if (seen_a.size() >= 5) chk("t3_line4_first", seen_a[4][63:56], 8'h20);
    chk("t3_done_count", done_a, 1);

    // Random gaps and backpressure, three back-to-back codewords
    run_a(3, 70, 50, -1, 0, -1, 1'b0);
    chk("t4_done_count", done_a, 3);
    chk("t4_nlines", seen_a.size(), 96);
    chk("t4_line_cnt_wrap", dut_a.u_ctrl.line_cnt_q, 0);

    // Abort a codeword after 100 bytes, reset, then a fresh codeword
    run_a(1, 100, 100, -1, 0, 100, 1'b0);
    do_reset(2);
    run_a(1, 80, 70, -1, 0, -1, 1'b1);
    if (seen_a.size() >= 1) chk("t5_first_line", seen_a[0], 64'h0001020304050607);
    chk("t5_done_count", done_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
